fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core: owns the program counter, issues word reads to instruction memory over a req/gnt/rvalid interface, buffers returned instructions with their PCs in a small queue, and presents them to decode (whose `instr[6:0]` drives `control_unit`) under a valid/ready handshake. Taken branches and jumps resolved downstream redirect the PC and flush all in-flight and buffered instructions.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, reset vector,
// base opcodes and the canonical NOP encoding.
package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} fetch entries.
// Ports: clk, rst_n (sync, active-low), flush, push/wdata,
//        pop, rdata (head entry), valid (non-empty), count.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = riscv_pkg::XLEN + 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    import riscv_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          full;
    logic          do_pop;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign do_pop = pop && (cnt != '0);
    assign rdata  = mem[rd_ptr];
    assign valid  = (cnt != '0);
    assign count  = cnt;

    // Flush dominates both push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            assert (!(push && full && !pop));
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem req/gnt/rvalid reads, {pc,instr} queue,
// valid/ready output to decode, redirect with flush of stale fetches.
// Ports: clk, rst_n; imem_req/addr/gnt/rvalid/rdata;
//        redirect_valid/pc; out_valid/ready/instr/pc.
module fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);
    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    resp_pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      discard;
    logic [CW-1:0]      q_count;
    logic               q_valid;
    logic [XLEN+31:0]   q_rdata;
    logic [CW:0]        used;
    logic               pop;
    logic               push;
    logic               gnt_ok;
    logic [XLEN-1:0]    target;
    logic               unused_bits;

    assign unused_bits = ^redirect_pc[1:0];
    assign target      = {redirect_pc[XLEN-1:2], 2'b00};

    assign out_valid = q_valid && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_pc    = q_rdata[XLEN+31:32];
    assign out_instr = q_rdata[31:0];

    // Credit counts an entry leaving this cycle as free, so a
    // 1-cycle memory streams at full rate with only 2 entries.
    // A response can still never meet a full queue.
    assign used = {1'b0, q_count} - {{CW{1'b0}}, pop}
                + {1'b0, outstanding};

    assign imem_req  = rst_n && !redirect_valid
                    && (used < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign gnt_ok    = imem_req && imem_gnt;

    assign push = imem_rvalid && !redirect_valid && (discard == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= {RESET_PC[XLEN-1:2], 2'b00};
            resp_pc     <= {RESET_PC[XLEN-1:2], 2'b00};
            outstanding <= '0;
            discard     <= '0;
        end else begin
            assert (!(imem_rvalid && outstanding == '0));
            outstanding <= outstanding + CW'(gnt_ok) - CW'(imem_rvalid);
            if (redirect_valid) begin
                fetch_pc <= target;
                resp_pc  <= target;
                // Every response still in flight predates the redirect;
                // outstanding already includes any pending discards.
                discard  <= outstanding - CW'(imem_rvalid);
            end else begin
                if (gnt_ok) fetch_pc <= fetch_pc + XLEN'(4);
                if (push)   resp_pc  <= resp_pc + XLEN'(4);
                if (imem_rvalid && discard != '0)
                    discard <= discard - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (XLEN + 32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({resp_pc, imem_rdata}),
        .pop   (pop),
        .rdata (q_rdata),
        .valid (q_valid),
        .count (q_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: variable-latency memory model
// plus a scoreboard of expected {pc, instr} in fetch order.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          gcyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    exp_t        sb[$];
    rsp_t        mq[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          lat = 1;
    logic [31:0] exp_fa = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[15:2], 2'b11};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h",
                   tag, obs, exp);
        end
    endtask

    // One clock: observe at mid-low phase, advance, drive memory.
    task automatic step();
        exp_t e;
        rsp_t r;
        int   due;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {31'b0, out_valid}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.instr);
                chk("latency", {31'b0, cyc >= e.gcyc + 2}, 32'h1);
            end
        end
        if (redirect_valid) begin
            sb.delete();
            exp_fa = {redirect_pc[31:2], 2'b00};
        end
        if (imem_req && imem_gnt) begin
            chk("imem_addr", imem_addr, exp_fa);
            sb.push_back('{exp_fa, memf(exp_fa), cyc});
            due = cyc + lat;
            if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
            mq.push_back('{imem_addr, due});
            exp_fa = exp_fa + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = memf(r.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        logic rdy;
        rdy = out_ready;
        out_ready = 1'b0;
        rst_n = 1'b0;
        imem_rvalid = 1'b0;
        mq.delete();
        for (int i = 0; i < n; i++) begin
            step();
            mq.delete();
            imem_rvalid = 1'b0;
        end
        sb.delete();
        exp_fa = 32'h0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        rst_n = 1'b1;
        out_ready = rdy;
        #1;
        chk("rel_req", {31'b0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'h0);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        #1;
        chk("rd_req_low", {31'b0, imem_req}, 32'h0);
        chk("rd_valid_low", {31'b0, out_valid}, 32'h0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rd_req", {31'b0, imem_req}, 32'h1);
        chk("rd_addr", imem_addr, {pc[31:2], 2'b00});
        chk("rd_gap", {31'b0, out_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset(2);

        for (int k = 0; k < 8; k++) begin
            if (k >= 2) begin
                chk("stream_valid", {31'b0, out_valid}, 32'h1);
                chk("stream_pc", out_pc, 32'(4 * (k - 2)));
            end
            step();
        end

        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (sb.size() > 0) chk("bp_hold_pc", out_pc, sb[0].pc);
            step();
        end
        #1;
        chk("bp_req", {31'b0, imem_req}, 32'h0);
        chk("bp_valid", {31'b0, out_valid}, 32'h1);
        out_ready = 1'b1;
        repeat (6) step();

        lat = 3;
        for (int i = 0; i < 20; i++) begin
            if (!imem_rvalid && mq.size() > 0) break;
            step();
        end
        redirect(32'h0000_0100);
        lat = 1;
        repeat (10) step();

        for (int i = 0; i < 10; i++) begin
            if (imem_rvalid) break;
            step();
        end
        redirect(32'h0000_0103);
        repeat (6) step();

        redirect(32'hFFFF_FFF8);
        repeat (8) step();

        for (int i = 0; i < 40; i++) begin
            imem_gnt  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            lat       = $urandom_range(1, 3);
            step();
        end
        imem_gnt = 1'b1;
        out_ready = 1'b1;
        lat = 1;
        repeat (4) step();

        out_ready = 1'b0;
        repeat (3) step();
        do_reset(1);
        out_ready = 1'b1;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
